// File: rtl/bcd_clock_if.sv
// Button, load and display bundle between the board front end and
// the time-of-day controller.
interface bcd_clock_if;
    logic        run_en;
    logic        mode_btn;
    logic        inc_btn;
    logic        load_en;
    logic [23:0] load_data;
    logic [7:0]  hh_out;
    logic [7:0]  mm_out;
    logic [7:0]  ss_out;
    logic [1:0]  set_sel;
    logic        sec_tick;
    logic        day_wrap;
    logic        load_err;

    modport master (
        output run_en, mode_btn, inc_btn, load_en, load_data,
        input  hh_out, mm_out, ss_out, set_sel,
        input  sec_tick, day_wrap, load_err
    );

    modport slave (
        input  run_en, mode_btn, inc_btn, load_en, load_data,
        output hh_out, mm_out, ss_out, set_sel,
        output sec_tick, day_wrap, load_err
    );
endinterface

// File: rtl/bcd_clock_ctrl.sv
// Time-of-day controller: one-second prescaler, cascaded BCD fields
// (ss/mm mod 60, hh mod 24) and a button-driven set FSM.
module bcd_clock_ctrl #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    bcd_clock_if.slave  bus
);
    localparam int unsigned W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] TC = W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SET_HH = 2'd1,
        SET_MM = 2'd2,
        SET_SS = 2'd3
    } state_e;

    state_e       state_q, state_d;
    logic [W-1:0] presc_q, presc_d;
    logic [7:0]   hh_q, hh_d;
    logic [7:0]   mm_q, mm_d;
    logic [7:0]   ss_q, ss_d;
    logic         tick_q, tick_d;
    logic         wrap_q, wrap_d;
    logic         err_q, err_d;
    logic         load_ok;

    function automatic logic [7:0] inc60(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5) r = 8'h00;
            else r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] inc24(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h23) r = 8'h00;
        else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
        else r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // Nibbles <= 9 keep BCD ordering identical to binary ordering.
    function automatic logic bcd_ok(input logic [7:0] v,
                                    input logic [7:0] max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    function automatic state_e next_state(input state_e s);
        state_e r;
        unique case (s)
            RUN:    r = SET_HH;
            SET_HH: r = SET_MM;
            SET_MM: r = SET_SS;
            SET_SS: r = RUN;
            default: r = RUN;
        endcase
        return r;
    endfunction

    assign load_ok = bcd_ok(bus.load_data[23:16], 8'h23)
                  && bcd_ok(bus.load_data[15:8], 8'h59)
                  && bcd_ok(bus.load_data[7:0], 8'h59);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            presc_q <= '0;
            hh_q    <= 8'h00;
            mm_q    <= 8'h00;
            ss_q    <= 8'h00;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            hh_q    <= hh_d;
            mm_q    <= mm_d;
            ss_q    <= ss_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        hh_d    = hh_q;
        mm_d    = mm_q;
        ss_d    = ss_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        if (bus.load_en) begin
            if (load_ok) begin
                hh_d    = bus.load_data[23:16];
                mm_d    = bus.load_data[15:8];
                ss_d    = bus.load_data[7:0];
                presc_d = '0;
            end else begin
                err_d = 1'b1;
            end
        end else if (bus.mode_btn) begin
            state_d = next_state(state_q);
            presc_d = '0;
        end else if (state_q != RUN) begin
            // Set states edit one field in isolation; no carries.
            if (bus.inc_btn) begin
                unique case (state_q)
                    SET_HH: hh_d = inc24(hh_q);
                    SET_MM: mm_d = inc60(mm_q);
                    SET_SS: ss_d = inc60(ss_q);
                    default: ;
                endcase
            end
        end else if (bus.run_en) begin
            if (presc_q == TC) begin
                presc_d = '0;
                tick_d  = 1'b1;
                ss_d    = inc60(ss_q);
                if (ss_q == 8'h59) begin
                    mm_d = inc60(mm_q);
                    if (mm_q == 8'h59) begin
                        hh_d   = inc24(hh_q);
                        wrap_d = (hh_q == 8'h23);
                    end
                end
            end else begin
                presc_d = presc_q + W'(1);
            end
        end
    end

    assign bus.hh_out   = hh_q;
    assign bus.mm_out   = mm_q;
    assign bus.ss_out   = ss_q;
    assign bus.set_sel  = state_q;
    assign bus.sec_tick = tick_q;
    assign bus.day_wrap = wrap_q;
    assign bus.load_err = err_q;
endmodule
